// File: rtl/mfp_timer_n.sv
// mfp_timer_n: parametrised MFP timer channel.
// Prescaled delay/pulse-width modes, event counting, one-shot.
module mfp_timer_n #(
  parameter int WIDTH      = 8,
  parameter int SYNC_DEPTH = 8,
  parameter bit T_EDGE     = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLK_EN,
  input  logic             DS,
  input  logic             DAT_WE,
  input  logic [WIDTH-1:0] DAT_I,
  output logic [WIDTH-1:0] DAT_O,
  input  logic             CTRL_WE,
  input  logic [5:0]       CTRL_I,
  output logic [4:0]       CTRL_O,
  input  logic             XCLK_I,
  input  logic             T_I,
  output logic             PULSE_MODE,
  output logic             EVENT_MODE,
  output logic             T_O,
  output logic             T_O_PULSE,
  output logic [WIDTH-1:0] SET_DATA_OUT
);

  localparam logic [3:0] MODE_STOP  = 4'd0;
  localparam logic [3:0] MODE_EVENT = 4'd8;

  logic [4:0]            ctrl_q, ctrl_d;
  logic [WIDTH-1:0]      data_q;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      dat_o_q;
  logic                  t_o_q, t_o_d;
  logic                  pulse_q;
  logic                  req_q, req_d;
  logic                  ds_q;

  logic                  xtog_q;
  logic                  xs1_q, xs2_q;
  logic                  xclk_en;
  logic [7:0]            pre_q, pre_d;
  logic [7:0]            div_m1;
  logic                  tick_q, tick_d;
  logic                  tick_seen_q;

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  trig, trig_d;

  logic [3:0]            mode;
  logic [2:0]            psel;
  logic                  stopped, ev_m, pw_m, dl_m;
  logic                  apply, tc, stop_wr;

  assign mode    = ctrl_q[3:0];
  assign psel    = mode[2:0];
  assign stopped = (mode == MODE_STOP);
  assign ev_m    = (mode == MODE_EVENT);
  assign pw_m    = mode[3] & (|mode[2:0]);
  assign dl_m    = ~mode[3] & (|mode[2:0]);

  // XCLK_I domain: a single toggle flop, resynchronised below
  always_ff @(posedge XCLK_I or negedge RST_N) begin
    if (!RST_N) xtog_q <= 1'b0;
    else        xtog_q <= ~xtog_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      xs1_q <= 1'b0;
      xs2_q <= 1'b0;
    end else begin
      xs1_q <= xtog_q;
      xs2_q <= xs1_q;
    end
  end

  assign xclk_en = xs1_q ^ xs2_q;

  always_comb begin
    case (psel)
      3'd1:    div_m1 = 8'd3;
      3'd2:    div_m1 = 8'd9;
      3'd3:    div_m1 = 8'd15;
      3'd4:    div_m1 = 8'd49;
      3'd5:    div_m1 = 8'd63;
      3'd6:    div_m1 = 8'd99;
      3'd7:    div_m1 = 8'd199;
      default: div_m1 = 8'd0;
    endcase
  end

  // >= so a prescaler change mid-phase cannot overrun the divisor
  always_comb begin
    pre_d  = pre_q;
    tick_d = tick_q;
    if (psel == 3'd0) begin
      pre_d = 8'd0;
    end else if (xclk_en) begin
      if (pre_q >= div_m1) begin
        pre_d  = 8'd0;
        tick_d = ~tick_q;
      end else begin
        pre_d = pre_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_q       <= 8'd0;
      tick_q      <= 1'b0;
      tick_seen_q <= 1'b0;
      sync_q      <= '0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      if (CLK_EN) begin
        tick_seen_q <= tick_q;
        sync_q      <= {sync_q[SYNC_DEPTH-2:0], T_I ^ ~T_EDGE};
      end
    end
  end

  assign trig   = sync_q[SYNC_DEPTH-1];
  assign trig_d = sync_q[SYNC_DEPTH-2];

  always_comb begin
    req_d = CLK_EN &
            ((ev_m & trig_d & ~trig) |
             ((dl_m | (pw_m & trig)) & (tick_q ^ tick_seen_q)));
  end

  assign apply   = req_q & ~stopped;
  assign tc      = apply & (cnt_q == WIDTH'(1));
  assign stop_wr = CTRL_WE & (CTRL_I[3:0] == MODE_STOP);

  always_comb begin
    ctrl_d = ctrl_q;
    if (CTRL_WE)
      ctrl_d = CTRL_I[4:0];
    else if (tc & ctrl_q[4])
      ctrl_d = 5'd0;
  end

  // A stop written on terminal count skips the reload and leaves 0
  always_comb begin
    cnt_d = cnt_q;
    if (DAT_WE & stopped)
      cnt_d = DAT_I;
    else if (tc & ~stop_wr)
      cnt_d = data_q;
    else if (apply)
      cnt_d = cnt_q - WIDTH'(1);
  end

  always_comb begin
    t_o_d = t_o_q ^ tc;
    if (CTRL_WE & CTRL_I[5])
      t_o_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ctrl_q  <= 5'd0;
      data_q  <= '0;
      cnt_q   <= '0;
      dat_o_q <= '0;
      t_o_q   <= 1'b0;
      pulse_q <= 1'b0;
      req_q   <= 1'b0;
      ds_q    <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      t_o_q   <= t_o_d;
      pulse_q <= tc;
      req_q   <= req_d;
      ds_q    <= DS;
      if (DAT_WE)
        data_q <= DAT_I;
      if (DS & ~ds_q)
        dat_o_q <= cnt_q;
    end
  end

  assign DAT_O        = dat_o_q;
  assign CTRL_O       = ctrl_q;
  assign T_O          = t_o_q;
  assign T_O_PULSE    = pulse_q;
  assign PULSE_MODE   = pw_m;
  assign EVENT_MODE   = ev_m;
  assign SET_DATA_OUT = data_q;

endmodule

// File: tb/tb_mfp_timer_n.sv
// tb_mfp_timer_n: scoreboard bench for mfp_timer_n.
// Instance A: 8-bit rising trigger; instance B: 16-bit falling trigger.
module tb_mfp_timer_n;

  logic        clk, rst_n, clk_en, ds, xclk;

  logic        dat_we_a, ctrl_we_a, t_i_a;
  logic [7:0]  dat_i_a, dat_o_a, set_a;
  logic [5:0]  ctrl_i_a;
  logic [4:0]  ctrl_o_a;
  logic        pm_a, em_a, to_a, top_a;

  logic        dat_we_b, ctrl_we_b, t_i_b;
  logic [15:0] dat_i_b, dat_o_b, set_b;
  logic [5:0]  ctrl_i_b;
  logic [4:0]  ctrl_o_b;
  logic        pm_b, em_b, to_b, top_b;

  int n_cmp = 0;
  int n_err = 0;
  int xe    = 0;
  int npa   = 0;
  int npb   = 0;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;
  exp_t sbq[$];

  mfp_timer_n #(.WIDTH(8), .SYNC_DEPTH(3), .T_EDGE(1'b1)) u_a (
    .CLK(clk), .RST_N(rst_n), .CLK_EN(clk_en), .DS(ds),
    .DAT_WE(dat_we_a), .DAT_I(dat_i_a), .DAT_O(dat_o_a),
    .CTRL_WE(ctrl_we_a), .CTRL_I(ctrl_i_a), .CTRL_O(ctrl_o_a),
    .XCLK_I(xclk), .T_I(t_i_a), .PULSE_MODE(pm_a), .EVENT_MODE(em_a),
    .T_O(to_a), .T_O_PULSE(top_a), .SET_DATA_OUT(set_a)
  );

  mfp_timer_n #(.WIDTH(16), .SYNC_DEPTH(2), .T_EDGE(1'b0)) u_b (
    .CLK(clk), .RST_N(rst_n), .CLK_EN(clk_en), .DS(ds),
    .DAT_WE(dat_we_b), .DAT_I(dat_i_b), .DAT_O(dat_o_b),
    .CTRL_WE(ctrl_we_b), .CTRL_I(ctrl_i_b), .CTRL_O(ctrl_o_b),
    .XCLK_I(xclk), .T_I(t_i_b), .PULSE_MODE(pm_b), .EVENT_MODE(em_b),
    .T_O(to_b), .T_O_PULSE(top_b), .SET_DATA_OUT(set_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // XCLK at CLK/4, phase kept clear of both CLK edges
  initial begin
    xclk = 1'b0;
    #2;
    forever #20 xclk = ~xclk;
  end

  always @(posedge xclk) xe <= xe + 1;
  always @(negedge clk) if (top_a) npa <= npa + 1;
  always @(negedge clk) if (top_b) npb <= npb + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk(e.tag, obs, e.v);
    end
  endtask

  task automatic dat_wr(input bit sel, input logic [15:0] v);
    @(negedge clk);
    if (sel) begin dat_we_b = 1'b1; dat_i_b = v; end
    else     begin dat_we_a = 1'b1; dat_i_a = v[7:0]; end
    @(negedge clk);
    dat_we_a = 1'b0;
    dat_we_b = 1'b0;
  endtask

  task automatic ctrl_wr(input bit sel, input logic [5:0] v);
    @(negedge clk);
    if (sel) begin ctrl_we_b = 1'b1; ctrl_i_b = v; end
    else     begin ctrl_we_a = 1'b1; ctrl_i_a = v; end
    @(negedge clk);
    ctrl_we_a = 1'b0;
    ctrl_we_b = 1'b0;
  endtask

  task automatic ds_read(input bit sel, output logic [31:0] v);
    @(negedge clk);
    ds = 1'b1;
    @(negedge clk);
    ds = 1'b0;
    v = sel ? 32'(dat_o_b) : 32'(dat_o_a);
  endtask

  task automatic wait_pulse(input bit sel, input int budget,
                            output int xe_at);
    bit hit;
    hit   = 1'b0;
    xe_at = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if ((sel ? top_b : top_a) == 1'b1) begin
        hit   = 1'b1;
        xe_at = xe;
      end
    end
    if (!hit) chk("pulse_timeout", 32'd0, 32'd1);
  endtask

  task automatic edges(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel) t_i_b = 1'b0; else t_i_a = 1'b1;
      @(negedge clk);
      if (sel) t_i_b = 1'b1; else t_i_a = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int x0, x1, base;

    rst_n = 1'b0; clk_en = 1'b1; ds = 1'b0;
    dat_we_a = 1'b0; ctrl_we_a = 1'b0; t_i_a = 1'b0;
    dat_i_a = '0; ctrl_i_a = '0;
    dat_we_b = 1'b0; ctrl_we_b = 1'b0; t_i_b = 1'b1;
    dat_i_b = '0; ctrl_i_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_ctrl", 32'(ctrl_o_a), 32'd0);
    chk("rst_dat_o", 32'(dat_o_a), 32'd0);
    chk("rst_t_o", 32'(to_a), 32'd0);
    chk("rst_pulse", 32'(top_a), 32'd0);
    chk("rst_data", 32'(set_a), 32'd0);

    // delay mode p=1, data 3: pulse every 12 XCLK edges
    dat_wr(1'b0, 16'd3);
    sb_push("ld_cnt", 32'd3);
    ds_read(1'b0, rd); sb_pop(rd);
    ctrl_wr(1'b0, 6'd1);
    wait_pulse(1'b0, 300, x0);
    sb_push("t_o_p1", 32'd1); sb_pop(32'(to_a));
    sb_push("reload1", 32'd3);
    ds_read(1'b0, rd); sb_pop(rd);
    wait_pulse(1'b0, 300, x1);
    sb_push("ival12a", 32'd12); sb_pop(32'(x1 - x0));
    sb_push("t_o_p2", 32'd0); sb_pop(32'(to_a));
    x0 = x1;
    wait_pulse(1'b0, 300, x1);
    sb_push("ival12b", 32'd12); sb_pop(32'(x1 - x0));
    sb_push("t_o_p3", 32'd1); sb_pop(32'(to_a));
    x0 = x1;

    // data write while running only updates data
    dat_wr(1'b0, 16'd7);
    sb_push("set_data", 32'd7); sb_pop(32'(set_a));
    sb_push("run_wr_cnt", 32'd3);
    ds_read(1'b0, rd); sb_pop(rd);
    wait_pulse(1'b0, 300, x1);
    sb_push("ival_old", 32'd12); sb_pop(32'(x1 - x0));
    sb_push("reload7", 32'd7);
    ds_read(1'b0, rd); sb_pop(rd);
    x0 = x1;
    wait_pulse(1'b0, 400, x1);
    sb_push("ival28", 32'd28); sb_pop(32'(x1 - x0));
    ctrl_wr(1'b0, 6'b100000);
    sb_push("t_o_clr", 32'd0); sb_pop(32'(to_a));

    // one-shot, data 2
    dat_wr(1'b0, 16'd2);
    ctrl_wr(1'b0, 6'b010001);
    wait_pulse(1'b0, 300, x0);
    sb_push("os_t_o", 32'd1); sb_pop(32'(to_a));
    sb_push("os_ctrl", 32'd0); sb_pop(32'(ctrl_o_a));
    sb_push("os_cnt", 32'd2);
    ds_read(1'b0, rd); sb_pop(rd);
    base = npa;
    repeat (200) @(negedge clk);
    sb_push("os_quiet", 32'(base)); sb_pop(32'(npa));

    // event mode: stop written on the terminal-count cycle
    dat_wr(1'b0, 16'd1);
    ctrl_wr(1'b0, 6'd8);
    sb_push("em_a", 32'd1); sb_pop(32'(em_a));
    @(negedge clk);
    t_i_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ctrl_we_a = 1'b1;
    ctrl_i_a  = 6'd0;
    @(negedge clk);
    ctrl_we_a = 1'b0;
    sb_push("stop_tc_pulse", 32'd1); sb_pop(32'(top_a));
    sb_push("stop_tc_t_o", 32'd0); sb_pop(32'(to_a));
    sb_push("stop_tc_ctrl", 32'd0); sb_pop(32'(ctrl_o_a));
    t_i_a = 1'b0;
    sb_push("stop_tc_cnt", 32'd0);
    ds_read(1'b0, rd); sb_pop(rd);
    repeat (5) @(negedge clk);
    ctrl_wr(1'b0, 6'd8);
    base = npa;
    edges(1'b0, 255);
    repeat (10) @(negedge clk);
    sb_push("wrap255", 32'(base)); sb_pop(32'(npa));
    sb_push("cnt255", 32'd1);
    ds_read(1'b0, rd); sb_pop(rd);
    edges(1'b0, 1);
    repeat (10) @(negedge clk);
    sb_push("wrap256", 32'(base + 1)); sb_pop(32'(npa));

    // 16-bit event mode, data 0, falling trigger
    dat_wr(1'b1, 16'd0);
    ctrl_wr(1'b1, 6'd8);
    sb_push("em_b", 32'd1); sb_pop(32'(em_b));
    base = npb;
    edges(1'b1, 1);
    repeat (8) @(negedge clk);
    sb_push("b_ffff", 32'hFFFF);
    ds_read(1'b1, rd); sb_pop(rd);
    sb_push("b_nopulse", 32'(base)); sb_pop(32'(npb));

    // pulse mode, T_EDGE=0: T_I high gates counting off
    ctrl_wr(1'b1, 6'd0);
    dat_wr(1'b1, 16'd3);
    ctrl_wr(1'b1, 6'd9);
    sb_push("pm_b", 32'd1); sb_pop(32'(pm_b));
    t_i_b = 1'b1;
    base = npb;
    repeat (600) @(negedge clk);
    sb_push("pm_hold_n", 32'(base)); sb_pop(32'(npb));
    sb_push("pm_hold_cnt", 32'd3);
    ds_read(1'b1, rd); sb_pop(rd);
    t_i_b = 1'b0;
    wait_pulse(1'b1, 400, x0);
    wait_pulse(1'b1, 400, x1);
    sb_push("pm_ival", 32'd12); sb_pop(32'(x1 - x0));

    // mid-run reset
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("mr_t_o", 32'(to_a), 32'd0);
    chk("mr_dat_o", 32'(dat_o_a), 32'd0);
    chk("mr_ctrl", 32'(ctrl_o_a), 32'd0);
    chk("mr_data", 32'(set_a), 32'd0);
    chk("mr_em", 32'(em_a), 32'd0);
    chk("mr_b_t_o", 32'(to_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ctrl", 32'(ctrl_o_a), 32'd0);
    chk("post_rst_pulse", 32'(top_a), 32'd0);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
